// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle through a shared
// 64-bit accumulator, with a start/busy/done handshake toward the pipeline control.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      dest,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wrt_addr,
    output logic            wrt_en
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          addr_q, addr_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                sgn_a, sgn_b, na, nb, is_div, ovf;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [XLEN:0]       sum, trial;
    logic [XLEN-1:0]     rem_sub, new_rem;
    logic                ge;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;

        sgn_a  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        na     = sgn_a & op_a[XLEN-1];
        nb     = sgn_b & op_b[XLEN-1];
        abs_a  = na ? -op_a : op_a;
        abs_b  = nb ? -op_b : op_b;
        is_div = funct3[2];
        ovf    = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

        // Multiply keeps the multiplier in the low half and shifts it out as the
        // partial sum shifts in from the top.
        sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Divide keeps {remainder, dividend/quotient}; quotient bits enter at the bottom.
        trial   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge      = trial >= {1'b0, opnd_q};
        rem_sub = trial[XLEN-1:0] - opnd_q;
        new_rem = ge ? rem_sub : trial[XLEN-1:0];

        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) state_d = ST_IDLE;
                if (start) begin
                    f3_d    = funct3;
                    addr_d  = dest;
                    neg_a_d = na;
                    neg_b_d = nb;
                    opnd_d  = is_div ? abs_b : abs_a;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                    count_d = '0;
                    state_d = ST_CALC;
                    if (is_div && (op_b == '0)) begin
                        result_d = funct3[1] ? op_a : '1;
                        state_d  = ST_DONE;
                    end else if (is_div && !funct3[0] && ovf) begin
                        result_d = funct3[1] ? '0 : op_a;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                if (f3_q[2]) acc_d = {new_rem, acc_q[XLEN-2:0], ge};
                else         acc_d = {sum, acc_q[XLEN-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == CW'(XLEN-1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                unique case (f3_q)
                    3'b000:                 result_d = prod[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         result_d = quo;
                    default:                result_d = rem;
                endcase
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            f3_q     <= '0;
            addr_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign busy     = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign wrt_addr = addr_q;
    assign wrt_en   = done && (addr_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results with their
// due cycle; a negedge monitor pops and compares whenever done is presented.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  dest;
    logic        busy, done, wrt_en;
    logic [31:0] result;
    logic [4:0]  wrt_addr;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  addr;
        logic        wen;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned last_e;
    int          checks = 0;
    int          errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .dest(dest),
        .busy(busy), .done(done), .result(result),
        .wrt_addr(wrt_addr), .wrt_en(wrt_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_result"},   64'(result),   64'(mon_e.res));
                    chk({mon_e.name, "_wrt_addr"}, 64'(wrt_addr), 64'(mon_e.addr));
                    chk({mon_e.name, "_wrt_en"},   64'(wrt_en),   64'(mon_e.wen));
                    chk({mon_e.name, "_cycle"},    64'(cyc),      64'(mon_e.cyc));
                end
            end else begin
                chk("wrt_en_idle", 64'(wrt_en), 64'(0));
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] r, input bit sp,
                         input string nm);
        exp_t e;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; dest = d; start = 1'b1;
        last_e = cyc + 1;
        e.res  = r;
        e.addr = d;
        e.wen  = (d != 5'd0);
        e.cyc  = last_e + (sp ? 0 : 33);
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
        dest   = 5'($urandom);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk({nm, "_timeout"}, 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc != target) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; dest = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     64'(busy),     64'(0));
        chk("rst_done",     64'(done),     64'(0));
        chk("rst_result",   64'(result),   64'(0));
        chk("rst_wrt_addr", 64'(wrt_addr), 64'(0));
        chk("rst_wrt_en",   64'(wrt_en),   64'(0));
        reset = 1'b0;

        issue(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0, "mul");    drain("mul");
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 0, "mulh");   drain("mulh");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 0, "mulhu");  drain("mulhu");
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 0, "mulhsu"); drain("mulhsu");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,  5'd9,  32'hFFFF_FFFD, 0, "div");          drain("div");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,  5'd10, 32'hFFFF_FFFF, 0, "rem");          drain("rem");
        issue(3'b101, 32'd100,      32'd7,  5'd11, 32'd14,        0, "divu");          drain("divu");
        issue(3'b111, 32'd100,      32'd7,  5'd12, 32'd2,         0, "remu");          drain("remu");
        issue(3'b101, 32'd5,        32'd0,  5'd13, 32'hFFFF_FFFF, 1, "divu_by0");      drain("divu_by0");
        issue(3'b111, 32'd5,        32'd0,  5'd14, 32'd5,         1, "remu_by0");      drain("remu_by0");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, "div_ovf"); drain("div_ovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1, "rem_ovf"); drain("rem_ovf");

        // start during CALC must not disturb the running divide
        issue(3'b101, 32'd100, 32'd7, 5'd17, 32'd14, 0, "ignore");
        wait_cyc(last_e + 10);
        funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0; dest = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_busy", 64'(busy), 64'(1));
        drain("ignore");

        // asynchronous reset mid-operation
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd18, 32'hFFFF_FFFD, 0, "aborted");
        wait_cyc(last_e + 10);
        reset = 1'b1;
        #1;
        chk("abort_busy",     64'(busy),     64'(0));
        chk("abort_done",     64'(done),     64'(0));
        chk("abort_wrt_en",   64'(wrt_en),   64'(0));
        chk("abort_result",   64'(result),   64'(0));
        chk("abort_wrt_addr", 64'(wrt_addr), 64'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd19, 32'hFFFF_FFFF, 0, "post_rst"); drain("post_rst");

        // dest=0 suppresses the write; start held through DONE chains with no bubble
        issue(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 0, "mul_x0");
        wait_cyc(last_e + 32);
        begin
            exp_t e2;
            funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; dest = 5'd3; start = 1'b1;
            e2.res = 32'hFFFF_FFEB; e2.addr = 5'd3; e2.wen = 1'b1;
            e2.cyc = last_e + 34 + 33; e2.name = "b2b";
            sb.push_back(e2);
        end
        @(negedge clk);
        chk("b2b_done_seen", 64'(done), 64'(1));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'(1));
        drain("b2b");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
